// File: rtl/core_pkg.sv
// Shared decode-side types for the 5-stage RISC-V core: ALU op codes and the
// control bundle carried from ID into EX.
package core_pkg;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   typedef struct packed {
      logic       branch;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       alusrc;
      logic [1:0] aluop;
      logic       regwrite;
   } ctrl_t;

   localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: a valid load in EX whose destination is
// read by the valid instruction in ID. rs2 is compared even when unused.
module load_use_detect
   #(parameter int RAW = 5)
   (input  logic           ex_valid,
    input  logic           ex_memread,
    input  logic [RAW-1:0] ex_rd,
    input  logic           id_valid,
    input  logic [RAW-1:0] id_rs1,
    input  logic [RAW-1:0] id_rs2,
    output logic           hazard);

   logic rd_match;

   assign rd_match = (ex_rd == id_rs1) || (ex_rd == id_rs2);
   assign hazard   = ex_valid && ex_memread && (ex_rd != '0) && id_valid && rd_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, external stall and
// flush, and a saturating count of hazard bubbles.
module id_ex_stage
   import core_pkg::*;
   #(parameter int XLEN = 32,
     parameter int RAW  = 5,
     parameter int CNTW = 16)
   (input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic            id_branch_i,
    input  logic            id_memread_i,
    input  logic            id_memwrite_i,
    input  logic            id_memtoreg_i,
    input  logic            id_alusrc_i,
    input  logic            id_regwrite_i,
    input  logic [1:0]      id_aluop_i,
    input  logic [9:0]      id_funct_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [RAW-1:0]  id_rs1_i,
    input  logic [RAW-1:0]  id_rs2_i,
    input  logic [RAW-1:0]  id_rd_i,
    output logic            ex_valid_o,
    output logic            ex_branch_o,
    output logic            ex_memread_o,
    output logic            ex_memwrite_o,
    output logic            ex_memtoreg_o,
    output logic            ex_alusrc_o,
    output logic            ex_regwrite_o,
    output logic [1:0]      ex_aluop_o,
    output logic [9:0]      ex_funct_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_rs1_data_o,
    output logic [XLEN-1:0] ex_rs2_data_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [RAW-1:0]  ex_rs1_o,
    output logic [RAW-1:0]  ex_rs2_o,
    output logic [RAW-1:0]  ex_rd_o,
    output logic            hazard_o,
    output logic [CNTW-1:0] bubble_cnt_o);

   ctrl_t           id_ctrl;
   ctrl_t           ex_ctrl;
   logic            ex_valid;
   logic [9:0]      ex_funct;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_rs1_data;
   logic [XLEN-1:0] ex_rs2_data;
   logic [XLEN-1:0] ex_imm;
   logic [RAW-1:0]  ex_rs1;
   logic [RAW-1:0]  ex_rs2;
   logic [RAW-1:0]  ex_rd;
   logic [CNTW-1:0] bubble_cnt;
   logic            hazard;
   logic            load_bubble;

   assign id_ctrl = '{branch:   id_branch_i,
                      memread:  id_memread_i,
                      memwrite: id_memwrite_i,
                      memtoreg: id_memtoreg_i,
                      alusrc:   id_alusrc_i,
                      aluop:    id_aluop_i,
                      regwrite: id_regwrite_i};

   // Flow control: there is no valid/ready pair here. hazard_o is a hold
   // request to IF/ID and PC for one cycle; stall_i freezes this stage and
   // its sources must keep flush_i and the ID slot steady until it drops.
   load_use_detect #(.RAW(RAW)) u_load_use_detect
      (.ex_valid   (ex_valid),
       .ex_memread (ex_ctrl.memread),
       .ex_rd      (ex_rd),
       .id_valid   (id_valid_i),
       .id_rs1     (id_rs1_i),
       .id_rs2     (id_rs2_i),
       .hazard     (hazard));

   assign load_bubble = flush_i || hazard;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_ctrl     <= BUBBLE_CTRL;
         ex_valid    <= 1'b0;
         ex_funct    <= '0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
      end else if (!stall_i) begin
         if (load_bubble) begin
            ex_ctrl     <= BUBBLE_CTRL;
            ex_valid    <= 1'b0;
            ex_funct    <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
         end else begin
            // Invalid slots are captured unmodified; EX gates on ex_valid_o.
            ex_ctrl     <= id_ctrl;
            ex_valid    <= id_valid_i;
            ex_funct    <= id_funct_i;
            ex_pc       <= id_pc_i;
            ex_rs1_data <= id_rs1_data_i;
            ex_rs2_data <= id_rs2_data_i;
            ex_imm      <= id_imm_i;
            ex_rs1      <= id_rs1_i;
            ex_rs2      <= id_rs2_i;
            ex_rd       <= id_rd_i;
         end
      end
   end

   // Only hazard bubbles are counted; a flush on the same edge takes precedence.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bubble_cnt <= '0;
      end else if (!stall_i && !flush_i && hazard && (bubble_cnt != {CNTW{1'b1}})) begin
         bubble_cnt <= bubble_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      end
   end

   assign ex_valid_o    = ex_valid;
   assign ex_branch_o   = ex_ctrl.branch;
   assign ex_memread_o  = ex_ctrl.memread;
   assign ex_memwrite_o = ex_ctrl.memwrite;
   assign ex_memtoreg_o = ex_ctrl.memtoreg;
   assign ex_alusrc_o   = ex_ctrl.alusrc;
   assign ex_regwrite_o = ex_ctrl.regwrite;
   assign ex_aluop_o    = ex_ctrl.aluop;
   assign ex_funct_o    = ex_funct;
   assign ex_pc_o       = ex_pc;
   assign ex_rs1_data_o = ex_rs1_data;
   assign ex_rs2_data_o = ex_rs2_data;
   assign ex_imm_o      = ex_imm;
   assign ex_rs1_o      = ex_rs1;
   assign ex_rs2_o      = ex_rs2;
   assign ex_rd_o       = ex_rd;
   assign hazard_o      = hazard;
   assign bubble_cnt_o  = bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model
// of the ID/EX register, load-use rule and saturating bubble counter.
module tb_id_ex_stage;
   import core_pkg::*;

   localparam int XLEN    = 32;
   localparam int RAW     = 5;
   localparam int CNTW    = 4;
   localparam int CNT_MAX = (1 << CNTW) - 1;

   typedef struct packed {
      logic            valid;
      logic            branch;
      logic            memread;
      logic            memwrite;
      logic            memtoreg;
      logic            alusrc;
      logic [1:0]      aluop;
      logic            regwrite;
      logic [9:0]      funct;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [RAW-1:0]  rs1;
      logic [RAW-1:0]  rs2;
      logic [RAW-1:0]  rd;
   } ex_t;

   localparam int EXP_W = $bits(ex_t) + CNTW;

   // clock / reset
   logic clk = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk = ~clk;

   logic stall_i = 1'b0;
   logic flush_i = 1'b0;
   ex_t  id = '0;

   logic            ex_valid_o, ex_branch_o, ex_memread_o, ex_memwrite_o;
   logic            ex_memtoreg_o, ex_alusrc_o, ex_regwrite_o;
   logic [1:0]      ex_aluop_o;
   logic [9:0]      ex_funct_o;
   logic [XLEN-1:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
   logic [RAW-1:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
   logic            hazard_o;
   logic [CNTW-1:0] bubble_cnt_o;

   id_ex_stage #(.XLEN(XLEN), .RAW(RAW), .CNTW(CNTW)) dut
      (.clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
       .id_valid_i(id.valid), .id_branch_i(id.branch), .id_memread_i(id.memread),
       .id_memwrite_i(id.memwrite), .id_memtoreg_i(id.memtoreg), .id_alusrc_i(id.alusrc),
       .id_regwrite_i(id.regwrite), .id_aluop_i(id.aluop), .id_funct_i(id.funct),
       .id_pc_i(id.pc), .id_rs1_data_i(id.rs1_data), .id_rs2_data_i(id.rs2_data),
       .id_imm_i(id.imm), .id_rs1_i(id.rs1), .id_rs2_i(id.rs2), .id_rd_i(id.rd),
       .ex_valid_o(ex_valid_o), .ex_branch_o(ex_branch_o), .ex_memread_o(ex_memread_o),
       .ex_memwrite_o(ex_memwrite_o), .ex_memtoreg_o(ex_memtoreg_o), .ex_alusrc_o(ex_alusrc_o),
       .ex_regwrite_o(ex_regwrite_o), .ex_aluop_o(ex_aluop_o), .ex_funct_o(ex_funct_o),
       .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
       .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
       .hazard_o(hazard_o), .bubble_cnt_o(bubble_cnt_o));

   ex_t act;
   assign act = {ex_valid_o, ex_branch_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o,
                 ex_alusrc_o, ex_aluop_o, ex_regwrite_o, ex_funct_o, ex_pc_o,
                 ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o};

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [199:0] act_v, input logic [199:0] exp_v);
      checks++;
      if (act_v !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act_v, exp_v, $time);
      end
   endtask

   // behavioural model and scoreboard
   ex_t              m;
   int               m_cnt;
   logic [EXP_W-1:0] exp_q[$];
   logic             check_en = 1'b0;

   function automatic bit model_hazard();
      return m.valid && m.memread && (m.rd != 0) && id.valid &&
             ((m.rd == id.rs1) || (m.rd == id.rs2));
   endfunction

   always @(posedge clk or posedge rst_i) begin
      ex_t nxt;
      int  nc;
      if (rst_i) begin
         m     <= '0;
         m_cnt <= 0;
         exp_q.delete();
         exp_q.push_back('0);
      end else begin
         nxt = m;
         nc  = m_cnt;
         if (!stall_i) begin
            if (flush_i) nxt = '0;
            else if (model_hazard()) begin
               nxt = '0;
               nc  = (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
            end else nxt = id;
         end
         m     <= nxt;
         m_cnt <= nc;
         exp_q.push_back({nxt, nc[CNTW-1:0]});
      end
   end

   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (check_en && !rst_i) begin
         check("hazard_o", 200'(hazard_o), 200'(model_hazard()));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ex_bundle", 200'(act), 200'(e[EXP_W-1:CNTW]));
            check("bubble_cnt", 200'(bubble_cnt_o), 200'(e[CNTW-1:0]));
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic v, input logic mr, input logic rw, input logic [1:0] op,
                            input logic [RAW-1:0] r1, input logic [RAW-1:0] r2,
                            input logic [RAW-1:0] rd);
      id          = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      id.valid    = v;
      id.memread  = mr;
      id.regwrite = rw;
      id.aluop    = op;
      id.rs1      = r1;
      id.rs2      = r2;
      id.rd       = rd;
   endtask

   task automatic random_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         set_instr(($urandom_range(3, 0) != 0), $urandom_range(1, 0), $urandom_range(1, 0),
                   2'($urandom_range(3, 0)), RAW'($urandom_range(7, 0)),
                   RAW'($urandom_range(7, 0)), RAW'($urandom_range(7, 0)));
         stall_i = ($urandom_range(99, 0) < 15);
         flush_i = ($urandom_range(99, 0) < 10);
         tick();
      end
      stall_i = 1'b0;
      flush_i = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      check_en = 1'b1;
      random_cycles(20);

      // asynchronous reset between edges
      #2 rst_i = 1'b1;
      #1;
      check("rst_bundle", 200'(act), 200'(0));
      check("rst_cnt", 200'(bubble_cnt_o), 200'(0));
      rst_i = 1'b0;
      set_instr(1, 0, 1, ALUOP_RTYPE, 1, 2, 5);
      tick();
      check("rtype_regwrite", 200'(ex_regwrite_o), 200'(1));
      check("rtype_aluop", 200'(ex_aluop_o), 200'(2'b10));
      check("rtype_rd", 200'(ex_rd_o), 200'(5));
      check("rtype_valid", 200'(ex_valid_o), 200'(1));

      // load-use bubble
      set_instr(1, 1, 1, ALUOP_ADD, 2, 0, 6);
      tick();
      set_instr(1, 0, 1, ALUOP_RTYPE, 6, 1, 8);
      #1 check("lu_hazard", 200'(hazard_o), 200'(1));
      tick();
      check("lu_bubble_valid", 200'(ex_valid_o), 200'(0));
      check("lu_bubble_ctrl", 200'({ex_branch_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o,
                                    ex_alusrc_o, ex_aluop_o, ex_regwrite_o}), 200'(0));
      check("lu_cnt", 200'(bubble_cnt_o), 200'(1));
      check("lu_hazard_clear", 200'(hazard_o), 200'(0));
      tick();
      check("lu_add_rd", 200'(ex_rd_o), 200'(8));
      check("lu_add_valid", 200'(ex_valid_o), 200'(1));

      // x0 destination and no-match
      set_instr(1, 1, 1, ALUOP_ADD, 0, 0, 0);
      tick();
      set_instr(1, 0, 1, ALUOP_RTYPE, 0, 0, 3);
      #1 check("x0_hazard", 200'(hazard_o), 200'(0));
      tick();
      set_instr(1, 1, 1, ALUOP_ADD, 0, 0, 7);
      tick();
      set_instr(1, 0, 1, ALUOP_RTYPE, 3, 4, 9);
      #1 check("nomatch_hazard", 200'(hazard_o), 200'(0));
      tick();

      // stall beats flush and hazard
      set_instr(1, 1, 1, ALUOP_ADD, 0, 0, 6);
      tick();
      set_instr(1, 0, 1, ALUOP_RTYPE, 6, 1, 8);
      stall_i = 1'b1;
      flush_i = 1'b1;
      #1 check("stall_hazard", 200'(hazard_o), 200'(1));
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_rd", 200'(ex_rd_o), 200'(6));
         check("stall_memread", 200'(ex_memread_o), 200'(1));
         check("stall_cnt", 200'(bubble_cnt_o), 200'(1));
      end
      stall_i = 1'b0;
      tick();
      check("unstall_flush_valid", 200'(ex_valid_o), 200'(0));
      check("unstall_flush_cnt", 200'(bubble_cnt_o), 200'(1));
      flush_i = 1'b0;

      // flush coincident with hazard
      set_instr(1, 1, 1, ALUOP_ADD, 0, 0, 6);
      tick();
      set_instr(1, 0, 1, ALUOP_RTYPE, 2, 6, 8);
      flush_i = 1'b1;
      #1 check("fh_hazard", 200'(hazard_o), 200'(1));
      tick();
      check("fh_bubble_rd", 200'(ex_rd_o), 200'(0));
      check("fh_bubble_valid", 200'(ex_valid_o), 200'(0));
      check("fh_cnt", 200'(bubble_cnt_o), 200'(1));
      flush_i = 1'b0;

      random_cycles(600);

      // saturation
      for (int i = 0; i < CNT_MAX + 3; i++) begin
         set_instr(1, 1, 1, ALUOP_ADD, 0, 0, 9);
         tick();
         set_instr(1, 0, 1, ALUOP_RTYPE, 9, 0, 10);
         tick();
      end
      check("sat_cnt", 200'(bubble_cnt_o), 200'(4'hF));
      set_instr(0, 0, 0, ALUOP_ADD, 0, 0, 0);
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
